// File: rtl/buffer_writer.sv
// Write side of the four packed packet buffers drained by the buffer reader.
// Appends tagged 2-bit packets at the tail and mirrors the reader's head pops.
module buffer_writer #(
  parameter int DEPTH   = 6,
  parameter int ENTRY_W = 3,
  parameter int DROP_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [1:0]               in_data,
  input  logic [1:0]               in_sel,
  output logic                     in_ready,
  input  logic                     pop_valid,
  input  logic [1:0]               pop_sel,
  output logic [DEPTH*ENTRY_W-1:0] buffer1_o,
  output logic [DEPTH*ENTRY_W-1:0] buffer2_o,
  output logic [DEPTH*ENTRY_W-1:0] buffer3_o,
  output logic [DEPTH*ENTRY_W-1:0] buffer4_o,
  output logic [2:0]               fill1,
  output logic [2:0]               fill2,
  output logic [2:0]               fill3,
  output logic [2:0]               fill4,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_cnt
);

  localparam int BUF_W = DEPTH * ENTRY_W;
  localparam logic [2:0] FULL = 3'(DEPTH);

  logic [BUF_W-1:0] bufs     [4];
  logic [BUF_W-1:0] buf_nxt  [4];
  logic [2:0]       fills    [4];
  logic [2:0]       fill_nxt [4];
  logic             drop;

  // A pop on the selected buffer frees a slot in the same cycle, so a full
  // buffer still accepts when the reader is draining it.
  assign in_ready = (fills[in_sel] != FULL) ||
                    (pop_valid && (pop_sel == in_sel) && (fills[in_sel] != '0));

  // Pop shifts first; the push then lands at the post-pop fill index, which
  // yields the "write at old fill-1, fill unchanged" behaviour for push+pop.
  always_comb begin
    drop = 1'b0;
    for (int unsigned b = 0; b < 4; b++) begin
      buf_nxt[b]  = bufs[b];
      fill_nxt[b] = fills[b];
      if (pop_valid && (pop_sel == 2'(b)) && (fills[b] != '0)) begin
        buf_nxt[b]  = bufs[b] >> ENTRY_W;
        fill_nxt[b] = fills[b] - 3'd1;
      end
      if (in_valid && (in_sel == 2'(b))) begin
        if (fill_nxt[b] < FULL) begin
          for (int unsigned e = 0; e < DEPTH; e++) begin
            if (fill_nxt[b] == 3'(e)) begin
              buf_nxt[b][e*ENTRY_W +: ENTRY_W] = ENTRY_W'({in_data, 1'b1});
            end
          end
          fill_nxt[b] = fill_nxt[b] + 3'd1;
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned b = 0; b < 4; b++) begin
        bufs[b]  <= '0;
        fills[b] <= '0;
      end
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      for (int unsigned b = 0; b < 4; b++) begin
        bufs[b]  <= buf_nxt[b];
        fills[b] <= fill_nxt[b];
      end
      overflow <= drop;
      if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  assign buffer1_o = bufs[0];
  assign buffer2_o = bufs[1];
  assign buffer3_o = bufs[2];
  assign buffer4_o = bufs[3];
  assign fill1     = fills[0];
  assign fill2     = fills[1];
  assign fill3     = fills[2];
  assign fill4     = fills[3];

endmodule
